// File: rtl/mmm_credit_sched_if.sv
// Bus between the matrix-multiply scheduler and its surroundings.
//   master : start/control side (drives matrices_loaded, K, fifo_pop)
//   slave  : scheduler side (drives read addresses, MAC strobes, status)
// Widths are derived from the same M/N/MAXK the scheduler is built with.
interface mmm_credit_sched_if #(
  parameter int M    = 7,
  parameter int N    = 9,
  parameter int MAXK = 8
);
  localparam int K_BITS = $clog2(MAXK+1);
  localparam int AW     = $clog2(M*MAXK);
  localparam int BW     = $clog2(MAXK*N);

  logic              matrices_loaded;
  logic [K_BITS-1:0] K;
  logic              fifo_pop;
  logic              compute_finished;
  logic [AW-1:0]     A_read_addr;
  logic [BW-1:0]     B_read_addr;
  logic              valid_input;
  logic              clear_acc;
  logic              fifo_wr;
  logic              busy;

  modport master (
    output matrices_loaded, K, fifo_pop,
    input  compute_finished, A_read_addr, B_read_addr, valid_input,
           clear_acc, fifo_wr, busy
  );

  modport slave (
    input  matrices_loaded, K, fifo_pop,
    output compute_finished, A_read_addr, B_read_addr, valid_input,
           clear_acc, fifo_wr, busy
  );
endinterface

// File: rtl/mmm_credit_sched.sv
// Credit-based term scheduler for an M x N output matrix multiply.
// Walks (row, col, idx) with idx fastest, issuing one A/B read per cycle.
// Each dot product claims one output-FIFO credit on its idx=0 term; a
// popped FIFO entry returns one. Read valid/clear tags follow the memory
// latency (1 cycle); the FIFO write strobe follows MAC latency as well.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of mmm_credit_sched_if
//                in : matrices_loaded, K, fifo_pop
//                out: compute_finished, A/B_read_addr, valid_input,
//                     clear_acc, fifo_wr, busy
// MAC_LAT must be at least 1.
module mmm_credit_sched #(
  parameter int M          = 7,
  parameter int N          = 9,
  parameter int MAXK       = 8,
  parameter int MAC_LAT    = 4,
  parameter int FIFO_DEPTH = N
) (
  input  logic             clk,
  input  logic             reset,
  mmm_credit_sched_if.slave bus
);
  localparam int K_BITS = $clog2(MAXK+1);
  localparam int AW     = $clog2(M*MAXK);
  localparam int BW     = $clog2(MAXK*N);
  localparam int RW     = (M > 1) ? $clog2(M) : 1;
  localparam int CW     = (N > 1) ? $clog2(N) : 1;
  localparam int CRW    = $clog2(FIFO_DEPTH+1);
  localparam int WST    = 1 + MAC_LAT;

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [K_BITS-1:0] k_reg, idx;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic [CRW-1:0]    credit;
  logic              v_q, c_q, done_q;
  logic [WST-1:0]    w_pipe;

  logic start, done_set, issue, first_term, stall;
  logic last_idx, last_col, last_row, pending;

  assign first_term = (idx == '0);
  assign last_idx   = (idx == k_reg - K_BITS'(1));
  assign last_col   = (col == CW'(N-1));
  assign last_row   = (row == RW'(M-1));
  // Credit is judged on the registered count only: a pop in the same
  // cycle does not let an idx=0 term through.
  assign stall      = first_term && (credit == '0);
  assign issue      = (state == RUN) && !stall;
  assign pending    = v_q | (|w_pipe);

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done_set  = 1'b0;
    case (state)
      IDLE:
        if (bus.matrices_loaded) begin
          start     = 1'b1;
          state_nxt = (bus.K != '0) ? RUN : DRAIN;
        end
      RUN:
        if (stall) begin
          // A pop this cycle guarantees credit next cycle, so skip HOLD
          // and retry the same term straight away.
          if (!bus.fifo_pop) state_nxt = HOLD;
        end else if (last_idx && last_col && last_row) begin
          state_nxt = DRAIN;
        end
      HOLD:
        if (credit != '0) state_nxt = RUN;
      DRAIN:
        if (!pending) begin
          done_set  = 1'b1;
          state_nxt = IDLE;
        end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      k_reg  <= '0;
      row    <= '0;
      col    <= '0;
      idx    <= '0;
      credit <= CRW'(FIFO_DEPTH);
      v_q    <= 1'b0;
      c_q    <= 1'b0;
      done_q <= 1'b0;
      w_pipe <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= done_set;
      v_q    <= issue;
      c_q    <= issue && first_term;
      w_pipe <= {w_pipe[WST-2:0], issue && last_idx};

      if (start) begin
        k_reg <= bus.K;
        row   <= '0;
        col   <= '0;
        idx   <= '0;
      end else if (issue) begin
        if (last_idx) begin
          idx <= '0;
          if (last_col) begin
            col <= '0;
            row <= row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end else begin
          idx <= idx + K_BITS'(1);
        end
      end

      case ({issue && first_term, bus.fifo_pop})
        2'b10:   credit <= credit - CRW'(1);
        2'b01:   if (credit != CRW'(FIFO_DEPTH)) credit <= credit + CRW'(1);
        default: credit <= credit;
      endcase
    end
  end

  logic [AW-1:0] a_addr;
  logic [BW-1:0] b_addr;
  logic          addr_en;

  assign a_addr  = AW'(row) * AW'(k_reg) + AW'(idx);
  assign b_addr  = BW'(idx) * BW'(N) + BW'(col);
  // Counters are frozen in HOLD, so the pending term's address stays put.
  assign addr_en = ((state == RUN) || (state == HOLD)) && !reset;

  assign bus.A_read_addr      = addr_en ? a_addr : '0;
  assign bus.B_read_addr      = addr_en ? b_addr : '0;
  assign bus.valid_input      = v_q & ~reset;
  assign bus.clear_acc        = c_q & ~reset;
  assign bus.fifo_wr          = w_pipe[WST-1] & ~reset;
  assign bus.compute_finished = done_q & ~reset;
  assign bus.busy             = (state != IDLE) & ~reset;
endmodule

// File: tb/tb_mmm_credit_sched.sv
module tb_mmm_credit_sched;
  localparam int M = 2, N = 3, MAXK = 4, LAT = 4, DEPTH = 3;
  localparam int AW = $clog2(M*MAXK);
  localparam int BW = $clog2(MAXK*N);
  localparam int NC = 8192;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mmm_credit_sched_if #(.M(M), .N(N), .MAXK(MAXK)) bus();

  mmm_credit_sched #(.M(M), .N(N), .MAXK(MAXK), .MAC_LAT(LAT), .FIFO_DEPTH(DEPTH))
    dut (.clk(clk), .reset(reset), .bus(bus));

  // ---------------- behavioural model ----------------
  // Pending terms live in a queue built from the nested loops; every issue
  // schedules its effects at absolute future cycle numbers.
  typedef struct { int a; int b; bit c; bit w; } term_t;
  typedef enum int {MD_IDLE, MD_RUN, MD_HOLD, MD_DRAIN} md_t;

  term_t tq[$];
  md_t   mode = MD_IDLE;
  int    credit = DEPTH;
  int    cyc = 0;
  bit    model_ok = 0;
  bit    sch_vi [NC];
  bit    sch_ca [NC];
  bit    sch_wr [NC];
  bit    sch_fin[NC];

  always @(posedge clk) begin : model
    int    k;
    bit    took, pend;
    term_t t;
    took = 0;
    if (reset) begin
      mode = MD_IDLE;
      tq.delete();
      credit = DEPTH;
      for (int j = cyc + 1; j < NC; j++) begin
        sch_vi[j] = 0; sch_ca[j] = 0; sch_wr[j] = 0; sch_fin[j] = 0;
      end
      model_ok = 1;
    end else begin
      case (mode)
        MD_IDLE:
          if (bus.matrices_loaded) begin
            k = int'(bus.K);
            tq.delete();
            for (int r = 0; r < M; r++)
              for (int c = 0; c < N; c++)
                for (int i = 0; i < k; i++) begin
                  t.a = r*k + i; t.b = i*N + c; t.c = (i == 0); t.w = (i == k-1);
                  tq.push_back(t);
                end
            mode = (k != 0) ? MD_RUN : MD_DRAIN;
          end
        MD_RUN:
          if (tq[0].c && credit == 0) begin
            if (!bus.fifo_pop) mode = MD_HOLD;
          end else begin
            t = tq.pop_front();
            sch_vi[cyc+1] = 1;
            sch_ca[cyc+1] = t.c;
            if (t.w) sch_wr[cyc+1+LAT] = 1;
            took = t.c;
            if (tq.size() == 0) mode = MD_DRAIN;
          end
        MD_HOLD:
          if (credit > 0) mode = MD_RUN;
        MD_DRAIN: begin
          pend = sch_vi[cyc];
          for (int j = cyc; j <= cyc + LAT; j++) if (sch_wr[j]) pend = 1;
          if (!pend) begin
            sch_fin[cyc+1] = 1;
            mode = MD_IDLE;
          end
        end
        default: mode = MD_IDLE;
      endcase
      if (took && !bus.fifo_pop) credit--;
      else if (!took && bus.fifo_pop && credit < DEPTH) credit++;
    end
    cyc++;
  end

  // ---------------- checking ----------------
  int checks = 0, errs = 0;
  int vi_tot = 0, ca_tot = 0, wr_tot = 0, fin_tot = 0, fin_cyc = 0, run_cyc = 0;
  int a_log[$], b_log[$], iss_log[$];
  int start_cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic compare_loop();
    logic [4+AW+BW:0] act_v, exp_v;
    int  pa, pb;
    bit  pbusy, en;
    pa = 0; pb = 0; pbusy = 0;
    forever begin
      @(negedge clk);
      if (model_ok) begin
        if (reset) exp_v = '0;
        else begin
          en = (mode == MD_RUN) || (mode == MD_HOLD);
          exp_v = {mode != MD_IDLE, sch_vi[cyc], sch_ca[cyc], sch_wr[cyc], sch_fin[cyc],
                   en ? AW'(tq[0].a) : AW'(0), en ? BW'(tq[0].b) : BW'(0)};
        end
        act_v = {bus.busy, bus.valid_input, bus.clear_acc, bus.fifo_wr,
                 bus.compute_finished, bus.A_read_addr, bus.B_read_addr};
        checks++;
        if (act_v !== exp_v) begin
          errs++;
          $display("FAIL cycle%0d {busy,vi,ca,wr,fin,A,B} actual=%b expected=%b", cyc, act_v, exp_v);
        end
        if (bus.valid_input) begin
          vi_tot++;
          if (bus.clear_acc) ca_tot++;
          a_log.push_back(pa); b_log.push_back(pb); iss_log.push_back(cyc - 1);
        end
        if (bus.fifo_wr) wr_tot++;
        if (bus.compute_finished) begin fin_tot++; fin_cyc = cyc; end
        if (bus.busy && !pbusy) run_cyc = cyc;
        pa = int'(bus.A_read_addr); pb = int'(bus.B_read_addr); pbusy = bus.busy;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start(input int k);
    bus.K = k[2:0];
    bus.matrices_loaded = 1'b1;
    start_cyc = cyc;
    tick();
    bus.matrices_loaded = 1'b0;
  endtask

  task automatic wait_fin(input string nm, input int maxc);
    int f0, n;
    f0 = fin_tot; n = 0;
    while (fin_tot == f0 && n < maxc) begin tick(); n++; end
    chk({nm, "_finish_seen"}, int'(fin_tot != f0), 1);
  endtask

  int ea[12] = '{0,1,0,1,0,1,2,3,2,3,2,3};
  int eb[12] = '{0,3,1,4,2,5,0,3,1,4,2,5};
  int eo[4]  = '{0,1,2,4};
  int s_wr, s_fin, s_vi, s_ca, s_log;

  initial begin
    fork compare_loop(); join_none
    bus.matrices_loaded = 1'b0; bus.K = '0; bus.fifo_pop = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_addrA", int'(bus.A_read_addr), 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", bus.busy, 0);

    // M=2,N=3,K=2 with pops always granted
    bus.fifo_pop = 1'b1;
    s_wr = wr_tot; s_fin = fin_tot; s_log = a_log.size();
    start(2);
    wait_fin("k2", 200);
    chk("k2_writes", wr_tot - s_wr, 6);
    chk("k2_finish", fin_tot - s_fin, 1);
    chk("k2_terms", a_log.size() - s_log, 12);
    if (a_log.size() - s_log == 12)
      for (int i = 0; i < 12; i++) begin
        chk($sformatf("k2_A%0d", i), a_log[s_log+i], ea[i]);
        chk($sformatf("k2_B%0d", i), b_log[s_log+i], eb[i]);
      end
    repeat (3) tick();

    // credit exhausted at an idx=0 term while a pop arrives that cycle
    bus.fifo_pop = 1'b0;
    s_log = iss_log.size();
    start(1);
    repeat (3) tick();
    bus.fifo_pop = 1'b1;
    tick();
    bus.fifo_pop = 1'b0;
    repeat (6) tick();
    chk("pop_stall_issues", iss_log.size() - s_log, 4);
    if (iss_log.size() - s_log == 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("pop_stall_off%0d", i), iss_log[s_log+i] - run_cyc, eo[i]);
    chk("pop_stall_hold_busy", bus.busy, 1);
    bus.fifo_pop = 1'b1;
    wait_fin("pop_stall", 100);
    chk("pop_stall_total", iss_log.size() - s_log, 6);

    // K=0: nothing issued, finish two cycles after start
    s_vi = vi_tot; s_wr = wr_tot;
    start(0);
    wait_fin("k0", 20);
    chk("k0_fin_delay", fin_cyc - start_cyc, 2);
    chk("k0_valid", vi_tot - s_vi, 0);
    chk("k0_writes", wr_tot - s_wr, 0);

    // reset in the middle of a run
    start(2);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_valid", bus.valid_input, 0);
    chk("midrst_A", int'(bus.A_read_addr), 0);
    tick();
    s_wr = wr_tot;
    start(1);
    wait_fin("post_rst", 100);
    chk("post_rst_writes", wr_tot - s_wr, 6);
    repeat (2) tick();

    // FIFO never drained: only DEPTH dot products may start
    bus.fifo_pop = 1'b0;
    s_ca = ca_tot; s_wr = wr_tot;
    start(2);
    repeat (30) tick();
    chk("nopop_products", ca_tot - s_ca, 3);
    chk("nopop_hold_busy", bus.busy, 1);
    bus.fifo_pop = 1'b1;
    tick();
    bus.fifo_pop = 1'b0;
    repeat (20) tick();
    chk("onepop_products", ca_tot - s_ca, 4);
    bus.fifo_pop = 1'b1;
    wait_fin("nopop", 200);
    chk("nopop_writes", wr_tot - s_wr, 6);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule

// File: doc/mmm_credit_sched.md
MMM_CREDIT_SCHED -- requirements
Module: mmm_credit_sched

Interface
REQ-001 SHALL have parameter M, default 7: rows of A and of the output matrix.
REQ-002 SHALL have parameter N, default 9: columns of B and of the output matrix.
REQ-003 SHALL have parameter MAXK, default 8: largest supported inner dimension; K_BITS = $clog2(MAXK+1).
REQ-004 SHALL have parameter MAC_LAT, default 4: cycles from MAC input to valid MAC output.
REQ-005 SHALL have parameter FIFO_DEPTH, default N: output FIFO entries.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 clk  input  1  clock; all state updates on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 matrices_loaded  input  1  A and B are resident; a compute may start.
REQ-010 K  input  K_BITS  inner dimension; sampled on start.
REQ-011 fifo_pop  input  1  output FIFO handshake completed this cycle (TVALID&&TREADY).
REQ-012 compute_finished  output  1  one-cycle pulse; releases the input memories.
REQ-013 A_read_addr  output  $clog2(M*MAXK)  A read address.
REQ-014 B_read_addr  output  $clog2(MAXK*N)  B read address.
REQ-015 valid_input  output  1  MAC operand valid.
REQ-016 clear_acc  output  1  MAC loads the product instead of accumulating it.
REQ-017 fifo_wr  output  1  MAC result write strobe to the output FIFO.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement the states IDLE, RUN, HOLD and DRAIN.
REQ-020 IDLE: on matrices_loaded=1, SHALL latch K into k_reg and clear row, col and idx.
REQ-021 IDLE exit: SHALL go to RUN if K!=0, else to DRAIN.
REQ-022 RUN issues one term per cycle: A_read_addr=row*k_reg+idx, B_read_addr=idx*N+col.
REQ-023 Term order: idx increments fastest, then col, then row.
REQ-024 In IDLE and DRAIN, both read addresses SHALL be 0.
REQ-025 Credit counter: width $clog2(FIFO_DEPTH+1); resets to FIFO_DEPTH.
REQ-026 Credit: -1 when a dot product's idx=0 term issues; +1 on fifo_pop; unchanged when both occur in the same cycle.
REQ-027 Issuing an idx=0 term SHALL require credit>0; if credit==0 at idx=0, go to HOLD without issuing.
REQ-028 Terms with idx>0 SHALL NOT wait on credit.
REQ-029 HOLD: no issue; address outputs hold; return to RUN in the cycle after credit>0.
REQ-030 Credit SHALL never underflow or exceed FIFO_DEPTH.
REQ-031 Per-term issue tags: v=1, c=(idx==0), w=(idx==k_reg-1).
REQ-032 valid_input and clear_acc SHALL equal v and c delayed by 1 cycle (memory read latency).
REQ-033 fifo_wr SHALL equal w delayed by 1+MAC_LAT cycles, via a shift register.
REQ-034 After the last term issues (row=M-1, col=N-1, idx=k_reg-1), SHALL go to DRAIN.
REQ-035 DRAIN: when the delay line holds no pending w or v, pulse compute_finished for 1 cycle, then go to IDLE.
REQ-036 Exactly M*N fifo_wr pulses per compute when K>=1; none when K=0.
REQ-037 matrices_loaded SHALL be ignored outside IDLE.
REQ-038 An idx=0 issue and a fifo_pop in the same cycle at credit==0 SHALL stall.

Reset
REQ-039 reset SHALL force IDLE and clear row, col, idx, k_reg and all delay-line stages.
REQ-040 reset SHALL set credit to FIFO_DEPTH.
REQ-041 reset SHALL drive every output to 0, including when asserted mid-RUN, HOLD or DRAIN.
REQ-042 The first cycle after reset deassertion SHALL be IDLE.

Verification
REQ-043 M=2,N=3,K=2, fifo_pop tied 1 -> addresses A:0,1,0,1,0,1,2,3,... B:0,3,1,4,2,5,...; 6 fifo_wr pulses, the first 6 cycles after RUN entry; one compute_finished.
REQ-044 FIFO_DEPTH=3, fifo_pop=0, M=2,N=3,K=2 -> exactly 3 dot products issue, then HOLD; one fifo_pop -> exactly one more dot product issues.
REQ-045 K=0 -> no valid_input, no fifo_wr; compute_finished pulses 2 cycles after start.
REQ-046 credit=0 at an idx=0 term, with fifo_pop in that same cycle -> that cycle stalls; the term issues on the next cycle.
REQ-047 reset asserted mid-RUN -> all outputs 0 next cycle; a later K=1 run produces M*N writes and a correct credit count.
